// File: rtl/ps2_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scan_decoder_if
//  Description : Byte/character streams of the PS/2 scan-code decoder.
//                code_*  : scan-code bytes from the PS/2 receiver
//                          (one-cycle code_valid pulse).
//                char_*  : decoded ASCII towards the LCD writer
//                          (valid/ready handshake).
//                master  : the environment side (receiver + LCD writer).
//                slave   : the decoder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_scan_decoder_if;
  logic       code_valid;
  logic [7:0] code_data;
  logic       code_err;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (
    output code_valid, code_data, code_err, char_ready,
    input  char_valid, char_data
  );

  modport slave (
    input  code_valid, code_data, code_err, char_ready,
    output char_valid, char_data
  );
endinterface
`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scan_decoder
//  Description : Translates PS/2 set-2 scan codes into ASCII. It tracks the
//                E0/F0 prefixes and the shift keys, and queues characters in
//                a small FIFO so that a slow LCD writer never stalls the
//                keyboard path.
//  Ports       : clk, rst    - system clock, synchronous active-high reset
//                bus (slave) - code_* byte input, char_* handshake output
//                shift_led   - high while either shift key is held
//                overflow    - sticky, a character was dropped (FIFO full)
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  ps2_scan_decoder_if.slave    bus,
  output logic                 shift_led,
  output logic                 overflow
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  localparam logic [7:0] c_code_ext    = 8'hE0;
  localparam logic [7:0] c_code_brk    = 8'hF0;
  localparam logic [7:0] c_code_lshift = 8'h12;
  localparam logic [7:0] c_code_rshift = 8'h59;
  localparam logic [7:0] c_code_enter  = 8'h5A;

  // Prefix state machine
  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_ext     = 2'd1;
  localparam logic [1:0] c_st_brk     = 2'd2;
  localparam logic [1:0] c_st_ext_brk = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;

  logic               r_lshift;
  logic               r_rshift;

  logic               w_push;
  logic [7:0]         w_push_char;
  logic               w_lshift_set;
  logic               w_lshift_clr;
  logic               w_rshift_set;
  logic               w_rshift_clr;
  logic [8:0]         w_xlat;
  logic               w_byte_ok;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_overflow;
  logic               w_empty;
  logic               w_pop;
  logic               w_accept;

  // Make-code translation. Bit 8 flags a mapped code; bits 7:0 hold ASCII.
  // Letters are stored lowercase and shifted down by 0x20 for uppercase.
  function automatic logic [8:0] f_translate(input logic [7:0] code,
                                             input logic       upper);
    logic [7:0] letter;
    logic [8:0] result;
    letter = 8'h00;
    result = 9'h000;
    case (code)
      8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
    if (letter != 8'h00) begin
      result = {1'b1, (upper ? (letter - 8'h20) : letter)};
    end else begin
      case (code)
        8'h45: result = 9'h130;  8'h16: result = 9'h131;
        8'h1E: result = 9'h132;  8'h26: result = 9'h133;
        8'h25: result = 9'h134;  8'h2E: result = 9'h135;
        8'h36: result = 9'h136;  8'h3D: result = 9'h137;
        8'h3E: result = 9'h138;  8'h46: result = 9'h139;
        8'h29: result = 9'h120;
        8'h5A: result = 9'h10D;
        8'h66: result = 9'h108;
        default: result = 9'h000;
      endcase
    end
    return result;
  endfunction

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. A byte with a receive error cancels any prefix.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (bus.code_valid) begin
      if (bus.code_err) begin
        w_state_next = c_st_idle;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (bus.code_data == c_code_ext) begin
              w_state_next = c_st_ext;
            end else if (bus.code_data == c_code_brk) begin
              w_state_next = c_st_brk;
            end else begin
              w_state_next = c_st_idle;
            end
          end
          c_st_ext: begin
            w_state_next = (bus.code_data == c_code_brk) ? c_st_ext_brk : c_st_idle;
          end
          default: w_state_next = c_st_idle;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (push request and shift-key updates)
  // --------------------------------------------------------------------------
  assign w_byte_ok = bus.code_valid && !bus.code_err;

  always_comb begin
    w_push       = 1'b0;
    w_push_char  = 8'h00;
    w_lshift_set = 1'b0;
    w_lshift_clr = 1'b0;
    w_rshift_set = 1'b0;
    w_rshift_clr = 1'b0;
    // Translation sees the registered shift state, so a shift change only
    // affects bytes arriving on later edges.
    w_xlat       = f_translate(bus.code_data, r_lshift | r_rshift);
    if (w_byte_ok) begin
      case (r_state)
        c_st_idle: begin
          if (bus.code_data != c_code_ext && bus.code_data != c_code_brk) begin
            w_lshift_set = (bus.code_data == c_code_lshift);
            w_rshift_set = (bus.code_data == c_code_rshift);
            w_push       = w_xlat[8];
            w_push_char  = w_xlat[7:0];
          end
        end
        c_st_ext: begin
          if (bus.code_data == c_code_enter) begin
            w_push      = 1'b1;
            w_push_char = 8'h0D;
          end
        end
        c_st_brk: begin
          w_lshift_clr = (bus.code_data == c_code_lshift);
          w_rshift_clr = (bus.code_data == c_code_rshift);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
    end else begin
      if (w_lshift_set) begin
        r_lshift <= 1'b1;
      end else if (w_lshift_clr) begin
        r_lshift <= 1'b0;
      end
      if (w_rshift_set) begin
        r_rshift <= 1'b1;
      end else if (w_rshift_clr) begin
        r_rshift <= 1'b0;
      end
    end
  end

  assign shift_led = r_lshift | r_rshift;

  // --------------------------------------------------------------------------
  // Character FIFO. A push into a full FIFO is still accepted when the head
  // is popped in the same cycle: the write lands in the slot being freed.
  // --------------------------------------------------------------------------
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && bus.char_ready;
  assign w_accept = w_push && ((r_count < c_depth) || w_pop);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_push_char;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - c_cnt_one;
      end
      if (w_push && !w_accept) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.char_valid = !w_empty;
  assign bus.char_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_scan_decoder
//  Description : Self-checking bench for ps2_scan_decoder. A queue-based
//                reference model tracks prefixes, shift keys, the character
//                buffer and the sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_decoder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic shift_led;
  logic overflow;

  ps2_scan_decoder_if bus ();

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .shift_led (shift_led),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_q [$];
  bit         m_ls, m_rs, m_ovf, m_ext, m_brk;
  logic [7:0] char_map [logic [7:0]];
  bit         is_letter [logic [7:0]];
  logic [7:0] mapped_codes [$];

  function automatic void build_map();
    logic [7:0] lc [26];
    logic [7:0] dc [10];
    lc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
           8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
           8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    dc = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 26; i++) begin
      char_map[lc[i]]  = 8'(8'h61 + i);
      is_letter[lc[i]] = 1'b1;
      mapped_codes.push_back(lc[i]);
    end
    for (int i = 0; i < 10; i++) begin
      char_map[dc[i]] = 8'(8'h30 + i);
      mapped_codes.push_back(dc[i]);
    end
    char_map[8'h29] = 8'h20; mapped_codes.push_back(8'h29);
    char_map[8'h5A] = 8'h0D; mapped_codes.push_back(8'h5A);
    char_map[8'h66] = 8'h08; mapped_codes.push_back(8'h66);
  endfunction

  // Applies one clock cycle of stimulus to the DUT and the model together.
  task automatic step(input bit v, input logic [7:0] d, input bit e, input bit r);
    bit         pop;
    bit         push;
    logic [7:0] ch;
    pop  = (m_q.size() != 0) && r;
    push = 1'b0;
    ch   = 8'h00;
    if (v) begin
      if (e) begin
        m_ext = 1'b0; m_brk = 1'b0;
      end else if (!m_ext && !m_brk) begin
        if (d == 8'hE0) m_ext = 1'b1;
        else if (d == 8'hF0) m_brk = 1'b1;
        else begin
          if (char_map.exists(d)) begin
            push = 1'b1;
            ch   = char_map[d];
            if (is_letter.exists(d) && (m_ls || m_rs)) ch = ch - 8'h20;
          end
          if (d == 8'h12) m_ls = 1'b1;
          if (d == 8'h59) m_rs = 1'b1;
        end
      end else if (m_ext && !m_brk) begin
        if (d == 8'hF0) m_brk = 1'b1;
        else begin
          if (d == 8'h5A) begin push = 1'b1; ch = 8'h0D; end
          m_ext = 1'b0;
        end
      end else if (m_brk && !m_ext) begin
        if (d == 8'h12) m_ls = 1'b0;
        if (d == 8'h59) m_rs = 1'b0;
        m_brk = 1'b0;
      end else begin
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
    bus.code_valid = v;
    bus.code_data  = d;
    bus.code_err   = e;
    bus.char_ready = r;
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    bus.code_err   = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(ch);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.code_valid = 1'b0;
    bus.code_err   = 1'b0;
    bus.char_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_ls = 0; m_rs = 0; m_ovf = 0; m_ext = 0; m_brk = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.char_valid); end
    n_checks++; if (bus.char_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.char_data); end
    n_checks++; if (shift_led !== 1'b0) begin n_fail++; $display("FAIL reset_shift: got %b expected 0", shift_led); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 8'h1C, 0, 1);
    n_checks++; if (bus.char_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", bus.char_valid); end
    n_checks++; if (bus.char_data !== 8'h61) begin n_fail++; $display("FAIL basic_data: got %h expected 61", bus.char_data); end
    step(0, 8'h00, 0, 1);
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped: got %b expected 0", bus.char_valid); end
  endtask

  task automatic test_shift();
    do_reset();
    step(1, 8'h12, 0, 0);
    n_checks++; if (shift_led !== 1'b1) begin n_fail++; $display("FAIL shift_led_on: got %b expected 1", shift_led); end
    step(0, 8'h00, 0, 0);
    step(1, 8'h1C, 0, 0);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h1C, 0, 0);
    n_checks++; if (shift_led !== 1'b1) begin n_fail++; $display("FAIL shift_led_held: got %b expected 1", shift_led); end
    step(1, 8'hF0, 0, 0);
    step(1, 8'h12, 0, 0);
    n_checks++; if (shift_led !== 1'b0) begin n_fail++; $display("FAIL shift_led_off: got %b expected 0", shift_led); end
    step(1, 8'h1C, 0, 0);
    n_checks++; if (bus.char_data !== 8'h41) begin n_fail++; $display("FAIL shift_upper: got %h expected 41", bus.char_data); end
    step(0, 8'h00, 0, 1);
    n_checks++; if (bus.char_data !== 8'h61) begin n_fail++; $display("FAIL shift_lower: got %h expected 61", bus.char_data); end
    step(0, 8'h00, 0, 1);
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL shift_count: got valid %b expected 0", bus.char_valid); end
  endtask

  task automatic test_extended();
    do_reset();
    step(1, 8'hE0, 0, 0); step(1, 8'h5A, 0, 0);
    step(1, 8'hE0, 0, 0); step(1, 8'hF0, 0, 0); step(1, 8'h5A, 0, 0);
    step(1, 8'h5A, 0, 0);
    step(1, 8'h1C, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (bus.char_data !== 8'h0D) begin n_fail++; $display("FAIL ext_enter%0d: got %h expected 0d", i, bus.char_data); end
      step(0, 8'h00, 0, 1);
    end
    n_checks++; if (bus.char_data !== 8'h61) begin n_fail++; $display("FAIL ext_idle: got %h expected 61", bus.char_data); end
    n_checks++; if (shift_led !== 1'b0) begin n_fail++; $display("FAIL ext_shift: got %b expected 0", shift_led); end
    step(0, 8'h00, 0, 1);
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL ext_count: got valid %b expected 0", bus.char_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, codes[i], 0, 0);
      step(0, 8'h00, 0, 0);
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.char_data !== 8'(8'h31 + i)) begin n_fail++; $display("FAIL ovf_drain%0d: got %h expected %h", i, bus.char_data, 8'(8'h31 + i)); end
      step(0, 8'h00, 0, 1);
    end
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", bus.char_valid); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [4];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25};
    do_reset();
    for (int i = 0; i < 4; i++) step(1, codes[i], 0, 0);
    // Full FIFO: push and pop in the same cycle
    step(1, 8'h2E, 0, 1);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.char_data !== 8'(8'h32 + i)) begin n_fail++; $display("FAIL b2b_drain%0d: got %h expected %h", i, bus.char_data, 8'(8'h32 + i)); end
      step(0, 8'h00, 0, 1);
    end
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", bus.char_valid); end
  endtask

  task automatic test_err();
    do_reset();
    step(1, 8'hF0, 1, 0);
    step(1, 8'h1C, 0, 0);
    n_checks++; if (bus.char_data !== 8'h61) begin n_fail++; $display("FAIL err_prefix: got %h expected 61", bus.char_data); end
    step(0, 8'h00, 0, 1);
    step(1, 8'h59, 0, 0);
    step(1, 8'hF0, 1, 0);
    step(1, 8'h59, 0, 0);
    n_checks++; if (shift_led !== 1'b1) begin n_fail++; $display("FAIL err_shift: got %b expected 1", shift_led); end
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL err_nopush: got %b expected 0", bus.char_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 8'h12, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 8'h1C, 0, 0);
    step(1, 8'hF0, 0, 0);
    do_reset();
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", bus.char_valid); end
    n_checks++; if (shift_led !== 1'b0) begin n_fail++; $display("FAIL rmid_shift: got %b expected 0", shift_led); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf: got %b expected 0", overflow); end
    step(1, 8'h1C, 0, 0);
    n_checks++; if (bus.char_data !== 8'h61) begin n_fail++; $display("FAIL rmid_after: got %h expected 61", bus.char_data); end
  endtask

  task automatic test_random();
    bit         v, e, r;
    logic [7:0] d;
    int         sel;
    int         ready_pct;
    do_reset();
    ready_pct = 50;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n_checks++; if (bus.char_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", cyc, bus.char_valid, m_q.size() != 0); end
      n_checks++; if (bus.char_data !== ((m_q.size() != 0) ? m_q[0] : 8'h00)) begin n_fail++; $display("FAIL rnd_data c%0d: got %h expected %h", cyc, bus.char_data, (m_q.size() != 0) ? m_q[0] : 8'h00); end
      n_checks++; if (shift_led !== (m_ls | m_rs)) begin n_fail++; $display("FAIL rnd_shift c%0d: got %b expected %b", cyc, shift_led, m_ls | m_rs); end
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %b expected %b", cyc, overflow, m_ovf); end
      if (cyc % 60 == 0) ready_pct = $urandom_range(5, 95);
      if (cyc == 750) do_reset();
      sel = $urandom_range(0, 11);
      case (sel)
        0:       d = 8'hE0;
        1:       d = 8'hF0;
        2:       d = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        3:       d = 8'($urandom_range(0, 255));
        default: d = mapped_codes[$urandom_range(0, mapped_codes.size() - 1)];
      endcase
      v = ($urandom_range(0, 2) != 0);
      e = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(1, 100) <= ready_pct);
      step(v, d, e, r);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.code_valid = 1'b0;
    bus.code_data  = 8'h00;
    bus.code_err   = 1'b0;
    bus.char_ready = 1'b0;
    build_map();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_shift();
    test_extended();
    test_overflow();
    test_back_to_back();
    test_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Translates PS/2 set-2 scan-code bytes into ASCII characters for the LCD path. It sits directly downstream of the PS/2 serial receiver, which delivers one validated byte per frame. It sits upstream of the LCD write controller, which consumes characters through a valid/ready handshake. The block tracks make/break and extended prefixes and the shift state, and buffers decoded characters in a small FIFO so that slow LCD writes never stall the keyboard.

## Interface
- FIFO_DEPTH, 4, character buffer depth; power of two, ≥2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- code_valid  in  1  one-cycle pulse: code_data/code_err are valid this cycle.
- code_data  in  8  received scan-code byte.
- code_err  in  1  parity/framing error for this byte; qualified by code_valid.
- char_valid  out  1  FIFO head holds a character.
- char_data  out  8  ASCII of the FIFO head; 0x00 when empty.
- char_ready  in  1  consumer accepts the head when char_valid && char_ready.
- shift_led  out  1  high while either shift key is held.
- overflow  out  1  sticky: a character was dropped because the FIFO was full.

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). State advances only on code_valid.
- IDLE transitions:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte is a make code: translate, stay in IDLE.
- EXT transitions:
  - F0 → EXT_BRK.
  - 5A (keypad Enter) → push 0x0D, go to IDLE.
  - Any other byte → ignore, go to IDLE.
- BRK transitions:
  - 12 clears lshift; 59 clears rshift.
  - All other bytes produce no output.
  - Always returns to IDLE.
- EXT_BRK: any byte → IDLE; no output, shift unchanged.
- Make code 12 sets lshift; make code 59 sets rshift. shift_led = lshift | rshift.
- Letter map (make code → lowercase letter):
  - 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i
  - 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r
  - 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z
  - Lowercase ASCII (0x61–0x7A) when shift is clear; uppercase (0x41–0x5A) when shift is set.
- Other map entries:
  - Digits: 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9 → 0x30–0x39. Shift has no effect on digits.
  - 29 → 0x20; 5A → 0x0D; 66 → 0x08.
- Unmapped make codes, including the shift keys themselves, push nothing.
- Typematic repeats are repeated make codes and push repeated characters.
- code_err with code_valid: the byte is discarded; FSM → IDLE; lshift/rshift unchanged; no push.
- FIFO push rules:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the character is dropped and overflow is set. overflow clears only on rst.
- FIFO pop: when char_valid && char_ready.
- Pointers wrap modulo FIFO_DEPTH. The count needs log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - FSM IDLE.
  - FIFO empty; char_valid 0; char_data 0x00.
  - lshift, rshift, shift_led 0; overflow 0.
- Reset mid-operation discards any pending prefix and all buffered characters on the next clock edge.
- Latency: a make code with code_valid at edge N is visible as char_valid=1 with the correct char_data after edge N (i.e. at cycle N+1) when the FIFO was empty.
- A shift make/break at edge N affects translation of a byte arriving at edge N+1 or later.
- Handshake rules:
  - char_data is stable while char_valid && !char_ready.
  - After a pop, the next head appears in the following cycle.
  - Back-to-back pops sustain one character per cycle.
- Simultaneous push and pop:
  - On an empty FIFO: no pop (char_valid was 0); the push is accepted.
  - On a full FIFO: both are accepted; count stays at FIFO_DEPTH; overflow unchanged.
- code_valid never arrives on consecutive cycles from the receiver, but the block accepts it every cycle.

## Test plan
- Reset, then send 1C with char_ready=1 → one cycle later char_valid=1, char_data=0x61. Popped next cycle; char_valid returns to 0.
- Send 12, 1C, F0 1C, F0 12, 1C → FIFO delivers 0x41 then 0x61; shift_led high between 12 and F0 12.
- Send E0 5A, then E0 F0 5A, then 5A → exactly two characters 0x0D; FSM back in IDLE; shift_led 0.
- With char_ready=0, send 16 1E 26 25 2E (FIFO_DEPTH=4) → overflow=1. Raising char_ready drains 0x31 0x32 0x33 0x34 on consecutive cycles; 0x35 is absent.
- Send F0 with code_err=1, then 1C → output 0x61 (prefix discarded), not treated as a break.
- Hold 12 (shift_led=1) with two characters buffered, assert rst one cycle → char_valid=0, shift_led=0, overflow=0. A following 1C yields 0x61.
